// File: rtl/keycode_event_queue.sv
// Turns the keyboard keycode level into a queue of press/release/repeat events.
// Latency: an event from a change sampled in cycle N is at the head in N+1 (empty queue).
// Backpressure: ev_valid/ev_ready pop; events that do not fit are dropped and flag overflow.
module keycode_event_queue #(
  parameter int DEPTH         = 8,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [7:0]               keycode,
  output logic                     ev_valid,
  output logic [7:0]               ev_code,
  output logic                     ev_press,
  output logic                     ev_repeat,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(RMAX);

  // One queued event: {repeat, press, code}
  typedef struct packed {
    logic       rpt;
    logic       press;
    logic [7:0] code;
  } ev_t;

  // Storage and control state
  ev_t             mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      kc_prev_q;
  logic [CW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic            first_q, first_d;

  // Combinational event generation / queue bookkeeping
  logic            change;
  logic            rel_ev, prs_ev, rpt_fire;
  logic [CW-1:0]   rpt_thr;
  ev_t             ev0, ev1;
  logic [CNTW-1:0] n_ev, n_acc, free_slots;
  logic            dropped, pop, wr0, wr1;
  ev_t             head;

  // Detect key changes and the typematic threshold; build up to two ordered events
  always_comb begin
    change   = (keycode != kc_prev_q);
    rel_ev   = change && (kc_prev_q != 8'd0);
    prs_ev   = change && (keycode != 8'd0);
    rpt_thr  = first_q ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);
    // A change in the threshold cycle restarts timing instead of repeating
    rpt_fire = (REPEAT_EN != 0) && !change && (kc_prev_q != 8'd0) && (rpt_cnt_q == rpt_thr);

    ev0  = '0;
    ev1  = '0;
    n_ev = '0;
    if (rel_ev) begin
      ev0 = '{rpt: 1'b0, press: 1'b0, code: kc_prev_q};
      if (prs_ev) begin
        ev1  = '{rpt: 1'b0, press: 1'b1, code: keycode};
        n_ev = CNTW'(2);
      end else begin
        n_ev = CNTW'(1);
      end
    end else if (prs_ev) begin
      ev0  = '{rpt: 1'b0, press: 1'b1, code: keycode};
      n_ev = CNTW'(1);
    end else if (rpt_fire) begin
      ev0  = '{rpt: 1'b1, press: 1'b1, code: kc_prev_q};
      n_ev = CNTW'(1);
    end
  end

  // Accept events in order while space remains; a same-cycle pop frees nothing yet
  always_comb begin
    free_slots = CNTW'(DEPTH) - count_q;
    dropped    = (n_ev > free_slots);
    n_acc      = dropped ? free_slots : n_ev;
    wr0        = (n_acc >= CNTW'(1));
    wr1        = (n_acc == CNTW'(2));
    pop        = (count_q != '0) && ev_ready;

    wptr_d  = wptr_q + AW'(n_acc);
    rptr_d  = rptr_q + AW'(pop);
    count_d = count_q + n_acc - CNTW'(pop);

    // Set wins over clear when both land in the same cycle
    ovf_d = ovf_q;
    if (ovf_clear) ovf_d = 1'b0;
    if (dropped)   ovf_d = 1'b1;
  end

  // Typematic timer: restart on any change, idle at zero with no key held
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    first_d   = first_q;
    if (REPEAT_EN == 0) begin
      rpt_cnt_d = '0;
      first_d   = 1'b1;
    end else if (change) begin
      rpt_cnt_d = '0;
      first_d   = 1'b1;
    end else if (kc_prev_q == 8'd0) begin
      rpt_cnt_d = '0;
    end else if (rpt_fire) begin
      // Restarts even when the repeat itself was dropped
      rpt_cnt_d = '0;
      first_d   = 1'b0;
    end else begin
      rpt_cnt_d = rpt_cnt_q + CW'(1);
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_prev_q <= 8'd0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rpt_cnt_q <= '0;
      first_q   <= 1'b1;
    end else begin
      kc_prev_q <= keycode;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rpt_cnt_q <= rpt_cnt_d;
      first_q   <= first_d;
    end
  end

  // Event storage; contents are don't-care outside the valid window, so no reset
  always_ff @(posedge Clk) begin
    if (wr0) mem_q[wptr_q]          <= ev0;
    if (wr1) mem_q[wptr_q + AW'(1)] <= ev1;
  end

  // First-word fall-through head, forced to zero while empty
  always_comb begin
    head      = mem_q[rptr_q];
    ev_valid  = (count_q != '0);
    ev_code   = ev_valid ? head.code  : 8'd0;
    ev_press  = ev_valid ? head.press : 1'b0;
    ev_repeat = ev_valid ? head.rpt   : 1'b0;
    ev_count  = count_q;
    overflow  = ovf_q;
  end

endmodule
